// File: rtl/brubb_dl_router_if.sv
// HPS download bus: ioctl stream in, ROM write port out.
// master = HPS/loader side, slave = router side.
interface brubb_dl_router_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;

  modport master (
    output ioctl_download, ioctl_wr,
    output ioctl_index, ioctl_addr, ioctl_dout,
    input  dn_addr, dn_data, dn_wr
  );

  modport slave (
    input  ioctl_download, ioctl_wr,
    input  ioctl_index, ioctl_addr, ioctl_dout,
    output dn_addr, dn_data, dn_wr
  );
endinterface

// File: rtl/brubb_dl_router.sv
// Routes HPS download stream to ROM port and DIP regs,
// and sequences the game core reset around ROM loads.
module brubb_dl_router #(
  parameter int ROM_SIZE    = 98304,
  parameter int HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  brubb_dl_router_if.slave bus,
  output logic [7:0]  dsw0,
  output logic [7:0]  dsw1,
  output logic        core_reset,
  output logic        rom_loaded,
  output logic        rom_overflow,
  output logic [16:0] byte_count
);

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_HOLD, S_READY
  } state_t;

  localparam logic [7:0]  HOLD_INIT = 8'(HOLD_CYCLES);
  localparam logic [24:0] ROM_LIM   = 25'(ROM_SIZE);
  localparam logic [31:0] ROM_FULL  = 32'(ROM_SIZE);

  state_t      state_q, state_d;
  logic [1:0]  rst_sync_q, rst_sync_d;
  logic [7:0]  hold_q, hold_d;
  logic [16:0] cnt_q, cnt_d, cnt_base;
  logic        ovf_q, ovf_d;
  logic        loaded_q, loaded_d;
  logic        cr_q, cr_d;
  logic        wr_q, wr_d;
  logic [16:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  dsw0_q, dsw0_d;
  logic [7:0]  dsw1_q, dsw1_d;
  logic        run, restart;
  logic        start, rom_stb, rom_ok;
  logic        rom_oob, dip_stb;

  assign run     = rst_sync_q[1];
  assign start   = bus.ioctl_download &&
                   (bus.ioctl_index == 8'd0);
  assign rom_stb = bus.ioctl_wr && start;
  assign rom_ok  = rom_stb &&
                   (bus.ioctl_addr < ROM_LIM);
  assign rom_oob = rom_stb && !rom_ok;
  assign dip_stb = bus.ioctl_wr &&
                   (bus.ioctl_index == 8'd254) &&
                   (bus.ioctl_addr[24:1] == 24'd0);

  // Reset release synchronizer; assertion stays async.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Synchronizer flops.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  // Next state and hold countdown.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    restart = 1'b0;
    unique case (state_q)
      S_IDLE, S_READY: begin
        if (start) begin
          state_d = S_LOAD;
          restart = 1'b1;
        end
      end
      S_LOAD: begin
        if (!bus.ioctl_download) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (start) begin
          state_d = S_LOAD;
          restart = 1'b1;
        end else if (hold_q == 8'd1) begin
          state_d = S_READY;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (restart) hold_d = HOLD_INIT;
  end

  // ROM port, status flags and DIP capture.
  always_comb begin
    cnt_base = restart ? 17'd0 : cnt_q;
    cnt_d    = cnt_base;
    if (rom_ok && (cnt_base != '1))
      cnt_d = cnt_base + 17'd1;
    ovf_d    = (ovf_q && !restart) || rom_oob;
    loaded_d = loaded_q && !restart;
    if ((state_q == S_LOAD) && !bus.ioctl_download)
      loaded_d = ({15'd0, cnt_q} == ROM_FULL) &&
                 !ovf_q;
    wr_d   = rom_ok;
    addr_d = rom_ok ? bus.ioctl_addr[16:0] : addr_q;
    data_d = rom_ok ? bus.ioctl_dout : data_q;
    dsw0_d = dsw0_q;
    dsw1_d = dsw1_q;
    if (dip_stb && !bus.ioctl_addr[0])
      dsw0_d = bus.ioctl_dout;
    if (dip_stb && bus.ioctl_addr[0])
      dsw1_d = bus.ioctl_dout;
    cr_d = (state_d != S_READY);
  end

  // State and output registers, frozen until sync release.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      hold_q   <= 8'd0;
      cnt_q    <= 17'd0;
      ovf_q    <= 1'b0;
      loaded_q <= 1'b0;
      cr_q     <= 1'b1;
      wr_q     <= 1'b0;
      addr_q   <= 17'd0;
      data_q   <= 8'd0;
      dsw0_q   <= 8'd0;
      dsw1_q   <= 8'd0;
    end else if (run) begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      loaded_q <= loaded_d;
      cr_q     <= cr_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      dsw0_q   <= dsw0_d;
      dsw1_q   <= dsw1_d;
    end
  end

  assign bus.dn_wr   = wr_q;
  assign bus.dn_addr = addr_q;
  assign bus.dn_data = data_q;
  assign dsw0         = dsw0_q;
  assign dsw1         = dsw1_q;
  assign core_reset   = cr_q;
  assign rom_loaded   = loaded_q;
  assign rom_overflow = ovf_q;
  assign byte_count   = cnt_q;

endmodule

// File: tb/tb_brubb_dl_router.sv
// Bench for brubb_dl_router: ROM load, overflow,
// DIP capture, hold restart, reset abort, foreign index.
module tb_brubb_dl_router;

  localparam int RS = 8;
  localparam int HC = 4;

  logic clk_sys = 1'b0;
  logic reset_n;
  logic [7:0]  dsw0, dsw1;
  logic        core_reset, rom_loaded, rom_overflow;
  logic [16:0] byte_count;

  brubb_dl_router_if bus ();

  brubb_dl_router #(.ROM_SIZE(RS), .HOLD_CYCLES(HC)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .bus          (bus.slave),
    .dsw0         (dsw0),
    .dsw1         (dsw1),
    .core_reset   (core_reset),
    .rom_loaded   (rom_loaded),
    .rom_overflow (rom_overflow),
    .byte_count   (byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference: the game is either waiting for a ROM,
  // receiving one, counting down a reset hold, or running.
  localparam int NOROM = 0, RECV = 1, HOLDING = 2, RUN = 3;
  int          m_phase = NOROM;
  int          m_left = 0;
  int          m_bytes = 0;
  logic        m_wr = 1'b0;
  logic [16:0] m_addr = '0;
  logic [7:0]  m_data = '0;
  logic [7:0]  m_dsw0 = '0, m_dsw1 = '0;
  logic        m_ovf = 1'b0, m_loaded = 1'b0;

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = NOROM; m_left = 0; m_bytes = 0;
      m_wr = 0; m_addr = '0; m_data = '0;
      m_dsw0 = '0; m_dsw1 = '0;
      m_ovf = 0; m_loaded = 0;
    end else begin
      bit rom_req, strobe, fits;
      rom_req = bus.ioctl_download &&
                bus.ioctl_index == 8'd0;
      strobe  = rom_req && bus.ioctl_wr;
      fits    = int'(bus.ioctl_addr) < RS;
      if (bus.ioctl_wr && bus.ioctl_index == 8'd254) begin
        if (bus.ioctl_addr == 25'd0) m_dsw0 = bus.ioctl_dout;
        if (bus.ioctl_addr == 25'd1) m_dsw1 = bus.ioctl_dout;
      end
      if (m_phase == RECV && !bus.ioctl_download) begin
        m_phase  = HOLDING;
        m_loaded = (m_bytes == RS) && !m_ovf;
      end else if (rom_req && m_phase != RECV) begin
        m_phase = RECV; m_left = HC;
        m_bytes = 0; m_ovf = 0; m_loaded = 0;
      end else if (m_phase == HOLDING) begin
        if (m_left == 1) m_phase = RUN;
        else m_left = m_left - 1;
      end
      m_wr = strobe && fits;
      if (m_wr) begin
        m_addr = bus.ioctl_addr[16:0];
        m_data = bus.ioctl_dout;
        if (m_bytes < 131071) m_bytes = m_bytes + 1;
      end
      if (strobe && !fits) m_ovf = 1;
    end
  end

  int n_chk = 0, n_pass = 0, pulses = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h",
                  nm, act, req);
  endtask

  // One cycle: advance to negedge and compare against model.
  task automatic step();
    @(negedge clk_sys);
    chk("dn_wr", 32'(bus.dn_wr), 32'(m_wr));
    chk("dn_addr", 32'(bus.dn_addr), 32'(m_addr));
    chk("dn_data", 32'(bus.dn_data), 32'(m_data));
    chk("dsw0", 32'(dsw0), 32'(m_dsw0));
    chk("dsw1", 32'(dsw1), 32'(m_dsw1));
    chk("core_reset", 32'(core_reset),
        32'(m_phase != RUN));
    chk("rom_loaded", 32'(rom_loaded), 32'(m_loaded));
    chk("rom_overflow", 32'(rom_overflow), 32'(m_ovf));
    chk("byte_count", 32'(byte_count), 32'(m_bytes));
    if (bus.dn_wr) pulses++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic strobe(input logic [7:0] idx,
                        input logic [24:0] a,
                        input logic [7:0] d);
    bus.ioctl_index = idx;
    bus.ioctl_addr  = a;
    bus.ioctl_dout  = d;
    bus.ioctl_wr    = 1'b1;
    step();
    bus.ioctl_wr    = 1'b0;
    step();
  endtask

  task automatic dl_on(input logic [7:0] idx);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    step();
  endtask

  // Drop download, return cycles core_reset stayed high.
  task automatic dl_off_hold(output int n);
    bus.ioctl_download = 1'b0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (!core_reset) break;
      n++;
    end
    if (core_reset) chk("hold_timeout", 1, 0);
  endtask

  int p0, hl;
  logic cr_min;

  initial begin
    reset_n = 1'b0;
    bus.ioctl_download = 0; bus.ioctl_wr = 0;
    bus.ioctl_index = 0; bus.ioctl_addr = 0;
    bus.ioctl_dout = 0;
    steps(3);
    chk("rst_core_reset", 32'(core_reset), 1);
    chk("rst_dn_wr", 32'(bus.dn_wr), 0);
    reset_n = 1'b1;
    steps(5);

    // Full 8-byte image.
    p0 = pulses;
    dl_on(8'd0);
    for (int i = 0; i < 8; i++)
      strobe(8'd0, 25'(i), 8'(8'hA0 + i));
    chk("A_pulses", 32'(pulses - p0), 8);
    chk("A_last_data", 32'(bus.dn_data), 32'hA7);
    dl_off_hold(hl);
    chk("A_hold_len", 32'(hl), HC);
    chk("A_count", 32'(byte_count), 8);
    chk("A_loaded", 32'(rom_loaded), 1);

    // DIP bytes while running.
    p0 = pulses;
    dl_on(8'd254);
    strobe(8'd254, 25'd0, 8'h5A);
    strobe(8'd254, 25'd1, 8'hC3);
    strobe(8'd254, 25'd2, 8'hFF);
    bus.ioctl_download = 0;
    steps(2);
    chk("B_dsw0", 32'(dsw0), 32'h5A);
    chk("B_dsw1", 32'(dsw1), 32'hC3);
    chk("B_pulses", 32'(pulses - p0), 0);
    chk("B_core_reset", 32'(core_reset), 0);

    // Nine bytes into an eight-byte ROM.
    p0 = pulses;
    dl_on(8'd0);
    for (int i = 0; i < 9; i++)
      strobe(8'd0, 25'(i), 8'(8'h10 + i));
    dl_off_hold(hl);
    chk("C_pulses", 32'(pulses - p0), 8);
    chk("C_ovf", 32'(rom_overflow), 1);
    chk("C_loaded", 32'(rom_loaded), 0);
    chk("C_hold_len", 32'(hl), HC);
    chk("C_count", 32'(byte_count), 8);

    // Restart from HOLD with counter at 2.
    dl_on(8'd0);
    for (int i = 0; i < 8; i++)
      strobe(8'd0, 25'(i), 8'(8'h30 + i));
    bus.ioctl_download = 0;
    cr_min = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      cr_min = cr_min & core_reset;
    end
    bus.ioctl_download = 1'b1;
    step();
    cr_min = cr_min & core_reset;
    chk("D_count_clr", 32'(byte_count), 0);
    for (int i = 0; i < 6; i++) begin
      step();
      cr_min = cr_min & core_reset;
    end
    chk("D_core_reset_held", 32'(cr_min), 1);
    for (int i = 0; i < 8; i++)
      strobe(8'd0, 25'(i), 8'(8'h60 + i));
    dl_off_hold(hl);
    chk("D_hold_len", 32'(hl), HC);
    chk("D_loaded", 32'(rom_loaded), 1);

    // Foreign index download while running.
    p0 = pulses;
    dl_on(8'd1);
    for (int i = 0; i < 4; i++)
      strobe(8'd1, 25'(i), 8'(8'hE0 + i));
    bus.ioctl_download = 0;
    steps(2);
    chk("E_pulses", 32'(pulses - p0), 0);
    chk("E_core_reset", 32'(core_reset), 0);
    chk("E_loaded", 32'(rom_loaded), 1);

    // Reset after three bytes of a new image.
    dl_on(8'd0);
    for (int i = 0; i < 3; i++)
      strobe(8'd0, 25'(i), 8'(8'h70 + i));
    bus.ioctl_index = 0; bus.ioctl_addr = 25'd3;
    bus.ioctl_dout = 8'h73; bus.ioctl_wr = 1'b1;
    @(posedge clk_sys);
    #3 reset_n = 1'b0;
    #1;
    chk("F_dn_wr", 32'(bus.dn_wr), 0);
    chk("F_dn_addr", 32'(bus.dn_addr), 0);
    chk("F_dn_data", 32'(bus.dn_data), 0);
    chk("F_dsw0", 32'(dsw0), 0);
    chk("F_dsw1", 32'(dsw1), 0);
    chk("F_core_reset", 32'(core_reset), 1);
    chk("F_count", 32'(byte_count), 0);
    chk("F_loaded", 32'(rom_loaded), 0);
    chk("F_ovf", 32'(rom_overflow), 0);
    bus.ioctl_wr = 0; bus.ioctl_download = 0;
    steps(3);
    reset_n = 1'b1;
    p0 = pulses;
    steps(10);
    chk("F_no_pulses", 32'(pulses - p0), 0);
    chk("F_loaded_after", 32'(rom_loaded), 0);
    chk("F_core_reset_after", 32'(core_reset), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/brubb_dl_router.md
BRUBB_DL_ROUTER -- requirements
Module: brubb_dl_router

Interface
REQ-001 Parameter ROM_SIZE, default 98304, number of valid ROM bytes for index 0; valid addresses are 0..ROM_SIZE-1.
REQ-002 Parameter HOLD_CYCLES, default 16, number of clk_sys cycles core_reset stays asserted after a download ends; range 1..255.
REQ-003 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ioctl_download  in  1  HPS download active.
REQ-006 ioctl_wr  in  1  one-cycle byte strobe.
REQ-007 ioctl_index  in  8  stream selector: 0 = ROM, 254 = DIP switches, all others ignored.
REQ-008 ioctl_addr  in  25  byte address within the stream.
REQ-009 ioctl_dout  in  8  byte data.
REQ-010 dn_addr  out  17  ROM write address to the game core.
REQ-011 dn_data  out  8  ROM write data.
REQ-012 dn_wr  out  1  ROM write strobe, one cycle per byte.
REQ-013 dsw0, dsw1  out  8 each  captured DIP bytes.
REQ-014 core_reset  out  1  active-high reset to the game core and pause logic.
REQ-015 rom_loaded  out  1  a complete ROM image has been received.
REQ-016 rom_overflow  out  1  sticky flag: a ROM byte arrived at or beyond ROM_SIZE.
REQ-017 byte_count  out  17  number of ROM bytes accepted in the current or last download, saturating.

Function
REQ-018 State machine states:
- IDLE: power-up; no ROM yet.
- LOAD: download in progress.
- HOLD: post-download reset hold.
- READY: game running.
REQ-019 IDLE->LOAD and READY->LOAD occur on the first cycle ioctl_download=1 with ioctl_index=0.
REQ-020 On entry to LOAD, the block SHALL:
- clear byte_count, rom_loaded and rom_overflow;
- load the hold counter with HOLD_CYCLES.
REQ-021 LOAD->HOLD occurs on the cycle after ioctl_download is sampled 0.
REQ-022 In HOLD, the counter decrements once per cycle. HOLD->READY occurs on the cycle the counter reads 1, so core_reset deasserts exactly HOLD_CYCLES cycles after entering HOLD.
REQ-023 If ioctl_download with index 0 reasserts during HOLD, the block SHALL return to LOAD and restart per REQ-020.
REQ-024 core_reset SHALL be 1 in IDLE, LOAD and HOLD, and 0 only in READY; it is registered and glitch-free.
REQ-025 ROM writes: when ioctl_wr=1, ioctl_index=0, ioctl_download=1 and ioctl_addr<ROM_SIZE, the following cycle SHALL carry:
- dn_wr=1;
- dn_addr=ioctl_addr[16:0];
- dn_data=ioctl_dout.
Latency is exactly 1 cycle.
REQ-026 dn_wr SHALL be 0 on every cycle not produced by REQ-025; dn_addr and dn_data hold their last value.
REQ-027 A ROM strobe with ioctl_addr>=ROM_SIZE produces no dn_wr and sets rom_overflow.
REQ-028 Each accepted ROM byte increments byte_count by 1, saturating at 2^17-1 with no wrap.
REQ-029 On LOAD->HOLD, rom_loaded SHALL be set iff byte_count==ROM_SIZE and rom_overflow==0.
REQ-030 DIP capture: ioctl_wr=1, ioctl_index=254 and ioctl_addr[24:1]==0 writes ioctl_dout into dsw0 (addr[0]=0) or dsw1 (addr[0]=1) on the next edge.
REQ-031 DIP capture is independent of state and does not affect core_reset or state transitions.
REQ-032 Strobes with any other index, or index 254 at addr>=2, are ignored.
REQ-033 A download with an index other than 0 SHALL NOT cause LOAD entry.

Reset
REQ-034 While reset_n=0, the block SHALL immediately force:
- state=IDLE;
- dn_wr=0, dn_addr=0, dn_data=0;
- dsw0=0, dsw1=0;
- core_reset=1;
- rom_loaded=0, rom_overflow=0, byte_count=0;
- hold counter=0.
REQ-035 Reset asserted mid-LOAD or mid-HOLD SHALL abandon the transfer; after release the block waits in IDLE for a fresh index-0 download.
REQ-036 Release of reset_n is synchronous to clk_sys via a two-flop synchronizer; the first state update occurs no earlier than the second rising edge after release.

Verification
REQ-037 ROM_SIZE=8, HOLD_CYCLES=4; download 8 bytes at addr 0..7 with data 0xA0..0xA7 -> eight dn_wr pulses, each 1 cycle after its strobe with matching addr/data; byte_count=8; rom_loaded=1; core_reset falls exactly 4 cycles after HOLD entry.
REQ-038 ROM_SIZE=8; download 9 bytes (addr 0..8) -> 8 dn_wr pulses; rom_overflow=1; rom_loaded=0; core_reset still deasserts after the hold.
REQ-039 Index 254 writes 0x5A at addr 0 and 0xC3 at addr 1, then 0xFF at addr 2 -> dsw0=0x5A, dsw1=0xC3; no dn_wr; state unchanged.
REQ-040 Start a second index-0 download while in HOLD (counter=2) -> returns to LOAD, core_reset stays 1 continuously, byte_count clears to 0.
REQ-041 Assert reset_n=0 after 3 of 8 ROM bytes -> outputs reach reset values without a clock edge; after release, no dn_wr occurs until a new download; rom_loaded=0.
REQ-042 Index 1 download of 4 bytes from READY -> no dn_wr, core_reset stays 0, state stays READY.
